// File: rtl/laa_alu_arb_if.sv
// Handshake bundle between the two ALU requesters, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface laa_alu_arb_if #(
   parameter int XLEN = 32,
   parameter int OPW  = 4
);
   logic [1:0]      req_valid;
   logic [OPW-1:0]  req_op0;
   logic [OPW-1:0]  req_op1;
   logic [XLEN-1:0] req_a0;
   logic [XLEN-1:0] req_a1;
   logic [XLEN-1:0] req_b0;
   logic [XLEN-1:0] req_b1;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [XLEN-1:0] rsp_data;
   logic [1:0]      rsp_ready;
   logic [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_r;
   logic            busy;

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
      input  rsp_ready, alu_r,
      output req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b, busy
   );

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
      output rsp_ready, alu_r,
      input  req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b, busy
   );
endinterface

// File: rtl/laa_alu_arb.sv
// Two-requester arbiter/sequencer time-sharing one combinational ALU:
// accept -> registered operands (EXEC) -> registered result held until consumed (RESP).
module laa_alu_arb #(
   parameter int XLEN = 32,
   parameter int OPW  = 4,
   parameter bit RR   = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   laa_alu_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   state_t          state_next;
   logic            owner;
   logic            last_grant;
   logic            cand;
   logic            accept;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [XLEN-1:0] rsp_data;
   logic [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;

   // A tie goes to whoever was not granted last (RR) or always to requester 0.
   always_comb begin
      cand = 1'b0;
      case (bus.req_valid)
         2'b10:   cand = 1'b1;
         2'b11:   cand = RR ? ~last_grant : 1'b0;
         default: cand = 1'b0;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if (rst_n && state == IDLE)
         req_ready[cand] = bus.req_valid[cand];
   end

   assign accept = |(bus.req_valid & req_ready);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (bus.rsp_ready[owner]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_data   <= '0;
         rsp_valid  <= 2'b00;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  owner  <= cand;
                  alu_op <= cand ? bus.req_op1 : bus.req_op0;
                  alu_a  <= cand ? bus.req_a1  : bus.req_a0;
                  alu_b  <= cand ? bus.req_b1  : bus.req_b0;
                  if (RR)
                     last_grant <= cand;
               end
            end
            EXEC: begin
               rsp_data  <= bus.alu_r;
               rsp_valid <= owner ? 2'b10 : 2'b01;
            end
            RESP: begin
               if (bus.rsp_ready[owner])
                  rsp_valid <= 2'b00;
            end
            default: rsp_valid <= 2'b00;
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data;
   assign bus.alu_op    = alu_op;
   assign bus.alu_a     = alu_a;
   assign bus.alu_b     = alu_b;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_laa_alu_arb.sv
// Directed bench for laa_alu_arb: one round-robin instance and one fixed-priority
// instance, each driving a small behavioural ALU.
module tb_laa_alu_arb;
   localparam int XLEN = 32;
   localparam int OPW  = 4;
   localparam logic [OPW-1:0] ALU_ADD = 4'h0;
   localparam logic [OPW-1:0] ALU_SUB = 4'h1;
   localparam logic [OPW-1:0] ALU_XOR = 4'h4;
   localparam logic [OPW-1:0] ALU_SLL = 4'h5;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   laa_alu_arb_if #(.XLEN(XLEN), .OPW(OPW)) bus_rr ();
   laa_alu_arb_if #(.XLEN(XLEN), .OPW(OPW)) bus_fp ();

   laa_alu_arb #(.XLEN(XLEN), .OPW(OPW), .RR(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
   laa_alu_arb #(.XLEN(XLEN), .OPW(OPW), .RR(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] alu_model(input logic [OPW-1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << b[4:0];
         default: return '0;
      endcase
   endfunction

   always_comb bus_rr.alu_r = alu_model(bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b);
   always_comb bus_fp.alu_r = alu_model(bus_fp.alu_op, bus_fp.alu_a, bus_fp.alu_b);

   task automatic idle_inputs();
      bus_rr.req_valid = 2'b00; bus_rr.rsp_ready = 2'b00;
      bus_rr.req_op0 = '0; bus_rr.req_a0 = '0; bus_rr.req_b0 = '0;
      bus_rr.req_op1 = '0; bus_rr.req_a1 = '0; bus_rr.req_b1 = '0;
      bus_fp.req_valid = 2'b00; bus_fp.rsp_ready = 2'b00;
      bus_fp.req_op0 = '0; bus_fp.req_a0 = '0; bus_fp.req_b0 = '0;
      bus_fp.req_op1 = '0; bus_fp.req_a1 = '0; bus_fp.req_b1 = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus_rr.req_valid = 2'b11;
      #1;
      checks++;
      if (bus_rr.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", bus_rr.req_ready); end
      checks++;
      if (bus_rr.rsp_valid !== 2'b00 || bus_rr.busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_status: rsp_valid %b busy %b want 00/0", bus_rr.rsp_valid, bus_rr.busy);
      end
      checks++;
      if (bus_rr.alu_op !== '0 || bus_rr.alu_a !== '0 || bus_rr.alu_b !== '0 || bus_rr.rsp_data !== '0) begin
         errors++; $display("[TB] FAIL reset_regs: op %h a %h b %h data %h want zeros", bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b, bus_rr.rsp_data);
      end
      @(negedge clk);
      bus_rr.req_valid = 2'b00;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      bus_rr.req_valid = 2'b01; bus_rr.req_op0 = ALU_ADD; bus_rr.req_a0 = 32'd5; bus_rr.req_b0 = 32'd7;
      bus_rr.rsp_ready = 2'b01;
      #1;
      checks++;
      if (bus_rr.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready: got %b want 01", bus_rr.req_ready); end
      @(negedge clk);
      bus_rr.req_valid = 2'b00;
      checks++;
      if (bus_rr.alu_op !== ALU_ADD || bus_rr.alu_a !== 32'd5 || bus_rr.alu_b !== 32'd7 || bus_rr.busy !== 1'b1) begin
         errors++; $display("[TB] FAIL single_exec: op %h a %0d b %0d busy %b want 0/5/7/1", bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b, bus_rr.busy);
      end
      checks++;
      if (bus_rr.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_early_rsp: got %b want 00", bus_rr.rsp_valid); end
      @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b01 || bus_rr.rsp_data !== 32'd12) begin
         errors++; $display("[TB] FAIL single_rsp: valid %b data %0d want 01/12", bus_rr.rsp_valid, bus_rr.rsp_data);
      end
      @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b00 || bus_rr.busy !== 1'b0) begin
         errors++; $display("[TB] FAIL single_done: valid %b busy %b want 00/0", bus_rr.rsp_valid, bus_rr.busy);
      end
      bus_rr.rsp_ready = 2'b00;
   endtask

   task automatic test_round_robin();
      do_reset();
      bus_rr.req_valid = 2'b11; bus_rr.rsp_ready = 2'b11;
      bus_rr.req_op0 = ALU_SUB; bus_rr.req_a0 = 32'd10;   bus_rr.req_b0 = 32'd3;
      bus_rr.req_op1 = ALU_XOR; bus_rr.req_a1 = 32'hF0;   bus_rr.req_b1 = 32'h0F;
      #1;
      checks++;
      if (bus_rr.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rr_first_grant: got %b want 01", bus_rr.req_ready); end
      repeat (2) @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b01 || bus_rr.rsp_data !== 32'd7 || bus_rr.req_ready !== 2'b00) begin
         errors++; $display("[TB] FAIL rr_rsp0: valid %b data %h ready %b want 01/7/00", bus_rr.rsp_valid, bus_rr.rsp_data, bus_rr.req_ready);
      end
      @(negedge clk);
      checks++;
      if (bus_rr.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL rr_second_grant: got %b want 10", bus_rr.req_ready); end
      repeat (2) @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b10 || bus_rr.rsp_data !== 32'hFF) begin
         errors++; $display("[TB] FAIL rr_rsp1: valid %b data %h want 10/ff", bus_rr.rsp_valid, bus_rr.rsp_data);
      end
      @(negedge clk);
      checks++;
      if (bus_rr.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rr_third_grant: got %b want 01", bus_rr.req_ready); end
      bus_rr.req_valid = 2'b00; bus_rr.rsp_ready = 2'b00;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      bus_rr.req_valid = 2'b01; bus_rr.req_op0 = ALU_ADD; bus_rr.req_a0 = 32'd5; bus_rr.req_b0 = 32'd7;
      bus_rr.rsp_ready = 2'b00;
      @(negedge clk);
      bus_rr.req_valid = 2'b10; bus_rr.req_op1 = ALU_SUB; bus_rr.req_a1 = 32'd20; bus_rr.req_b1 = 32'd8;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus_rr.rsp_valid !== 2'b01 || bus_rr.rsp_data !== 32'd12 || bus_rr.busy !== 1'b1 ||
             bus_rr.req_ready !== 2'b00 || bus_rr.alu_a !== 32'd5) begin
            errors++; $display("[TB] FAIL bp_hold[%0d]: valid %b data %0d busy %b ready %b alu_a %0d want 01/12/1/00/5",
                               i, bus_rr.rsp_valid, bus_rr.rsp_data, bus_rr.busy, bus_rr.req_ready, bus_rr.alu_a);
         end
         @(negedge clk);
      end
      bus_rr.rsp_ready = 2'b01;
      @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b00 || bus_rr.req_ready !== 2'b10) begin
         errors++; $display("[TB] FAIL bp_release: valid %b ready %b want 00/10", bus_rr.rsp_valid, bus_rr.req_ready);
      end
   endtask

   task automatic test_nonowner_ignored();
      @(negedge clk);
      bus_rr.req_valid = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus_rr.rsp_valid !== 2'b10 || bus_rr.rsp_data !== 32'd12 || bus_rr.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL nonowner_hold[%0d]: valid %b data %0d busy %b want 10/12/1",
                               i, bus_rr.rsp_valid, bus_rr.rsp_data, bus_rr.busy);
         end
         @(negedge clk);
      end
      bus_rr.rsp_ready = 2'b10;
      @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b00 || bus_rr.busy !== 1'b0) begin
         errors++; $display("[TB] FAIL nonowner_release: valid %b busy %b want 00/0", bus_rr.rsp_valid, bus_rr.busy);
      end
      bus_rr.rsp_ready = 2'b00;
   endtask

   task automatic test_fixed_priority();
      @(negedge clk);
      bus_fp.req_valid = 2'b11; bus_fp.rsp_ready = 2'b11;
      bus_fp.req_op0 = ALU_ADD; bus_fp.req_a0 = 32'd1;  bus_fp.req_b0 = 32'd2;
      bus_fp.req_op1 = ALU_XOR; bus_fp.req_a1 = 32'hAA; bus_fp.req_b1 = 32'h55;
      for (int g = 0; g < 4; g++) begin
         #1;
         checks++;
         if (bus_fp.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL fp_grant[%0d]: got %b want 01", g, bus_fp.req_ready); end
         repeat (2) @(negedge clk);
         checks++;
         if (bus_fp.rsp_valid !== 2'b01 || bus_fp.rsp_data !== 32'd3) begin
            errors++; $display("[TB] FAIL fp_rsp[%0d]: valid %b data %0d want 01/3", g, bus_fp.rsp_valid, bus_fp.rsp_data);
         end
         @(negedge clk);
      end
      bus_fp.req_valid = 2'b00; bus_fp.rsp_ready = 2'b00;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus_rr.req_valid = 2'b01; bus_rr.req_op0 = ALU_ADD; bus_rr.req_a0 = 32'd9; bus_rr.req_b0 = 32'd9;
      bus_rr.rsp_ready = 2'b11;
      @(negedge clk);
      bus_rr.req_valid = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_rr.busy !== 1'b0 || bus_rr.rsp_valid !== 2'b00 || bus_rr.alu_a !== '0 ||
          bus_rr.alu_op !== '0 || bus_rr.rsp_data !== '0 || bus_rr.req_ready !== 2'b00) begin
         errors++; $display("[TB] FAIL async_reset: busy %b valid %b alu_a %0d op %h data %0d ready %b want all zero",
                            bus_rr.busy, bus_rr.rsp_valid, bus_rr.alu_a, bus_rr.alu_op, bus_rr.rsp_data, bus_rr.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus_rr.rsp_valid !== 2'b00 || bus_rr.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL async_stale[%0d]: valid %b busy %b want 00/0", i, bus_rr.rsp_valid, bus_rr.busy);
         end
      end
      bus_rr.req_valid = 2'b10; bus_rr.req_op1 = ALU_SLL; bus_rr.req_a1 = 32'd1; bus_rr.req_b1 = 32'd4;
      #1;
      checks++;
      if (bus_rr.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL async_new_grant: got %b want 10", bus_rr.req_ready); end
      @(negedge clk);
      bus_rr.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (bus_rr.rsp_valid !== 2'b10 || bus_rr.rsp_data !== 32'd16) begin
         errors++; $display("[TB] FAIL async_new_rsp: valid %b data %0d want 10/16", bus_rr.rsp_valid, bus_rr.rsp_data);
      end
      @(negedge clk);
      bus_rr.rsp_ready = 2'b00;
   endtask

   // Directed scenarios run back to back; later ones rely on the state earlier ones leave.
   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_inputs();
      do_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_nonowner_ignored();
      test_fixed_priority();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/laa_alu_arb.md
Name: laa_alu_arb

Overview:
- Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (laa_alu).
- Accepts operation requests (op, a, b) from requester 0 and requester 1 over valid/ready handshakes.
- Registers the granted operands onto the ALU inputs, captures the ALU result one cycle later, and returns it to the owning requester through a response valid/ready handshake.
- Sits between the execute-stage users and the single ALU instance, so the ALU is time-shared without combinational paths from requester inputs to the ALU.

Parameters:
- XLEN, 32, operand/result width; must match the ALU.
- OPW, 4, ALU opcode width; must match the ALU.
- RR, 1, 1 = round-robin tie-break; 0 = fixed priority with requester 0 always winning ties.

Ports:
- arb_i_clk  input  1  clock; all state updates on the rising edge.
- arb_i_rst_n  input  1  reset; asynchronous assert, active-low.
- arb_i_req_valid  input  2  bit k: requester k presents a request.
- arb_i_req_op0 / arb_i_req_op1  input  OPW  ALU opcode for requester 0 / 1.
- arb_i_req_a0 / arb_i_req_a1  input  XLEN  operand a for requester 0 / 1.
- arb_i_req_b0 / arb_i_req_b1  input  XLEN  operand b for requester 0 / 1.
- arb_o_req_ready  output  2  bit k: request k is accepted this cycle.
- arb_o_rsp_valid  output  2  bit k: the response for requester k is valid.
- arb_o_rsp_data  output  XLEN  result; shared by both requesters, qualified by arb_o_rsp_valid.
- arb_i_rsp_ready  input  2  bit k: requester k consumes its response.
- arb_o_alu_op  output  OPW  registered opcode to the ALU.
- arb_o_alu_a  output  XLEN  registered operand a to the ALU.
- arb_o_alu_b  output  XLEN  registered operand b to the ALU.
- arb_i_alu_r  input  XLEN  combinational ALU result.
- arb_o_busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (arb_i_rst_n = 0, asynchronous):
  - state = IDLE, owner = 0, last-grant pointer = 1 (requester 0 wins the first tie).
  - arb_o_alu_op/a/b = 0, arb_o_rsp_data = 0.
  - arb_o_rsp_valid = 2'b00, arb_o_busy = 0.
  - arb_o_req_ready is forced to 2'b00 while reset is asserted.
- A reset mid-operation discards the in-flight op; no response is ever produced for it.
- States: IDLE -> EXEC -> RESP -> IDLE. No other transitions; illegal encodings return to IDLE.
- IDLE:
  - arb_o_req_ready is one-hot or zero. It is asserted only for the grant candidate, and only if that requester's valid bit is set.
  - Candidate selection: if exactly one valid bit is set, that requester. If both are set: with RR=1, the requester not equal to the last-grant pointer; with RR=0, requester 0.
  - Handshake = valid & ready in the same cycle. On that edge:
    - latch op/a/b of the winner into arb_o_alu_*;
    - owner = winner; pointer = winner (when RR=1);
    - state -> EXEC.
- EXEC (one cycle):
  - arb_o_req_ready = 0.
  - At the edge: arb_o_rsp_data <= arb_i_alu_r, arb_o_rsp_valid[owner] <= 1, state -> RESP.
- RESP:
  - arb_o_rsp_valid[owner] and arb_o_rsp_data are held stable until arb_i_rsp_ready[owner] = 1.
  - arb_i_rsp_ready of the non-owner is ignored.
  - On the handshake edge: rsp_valid clears, state -> IDLE.
  - arb_o_req_ready = 0 throughout RESP.
- arb_o_alu_op/a/b change only on the IDLE accept edge. They are stable through EXEC and RESP.
- Latency: request accepted at the end of cycle n -> arb_o_rsp_valid high from cycle n+2.
- Throughput: one op per 3 cycles minimum, when rsp_ready is held high.
- Requester obligations: hold valid and payload stable until ready. Arbiter obligations: rsp_valid never depends combinationally on rsp_ready; req_ready may depend combinationally on req_valid.
- No arithmetic inside the block. The result is passed through at full XLEN width with no modification.
- Fairness: with RR=1 and both requesters continuously valid, grants strictly alternate 0,1,0,1...
- arb_o_busy = (state != IDLE).

Test Plan:
- Reset then single request: req0 `ALU_ADD a=5 b=7 held valid -> ready[0] pulses the same cycle; alu_op/a/b = ADD/5/7 in EXEC; rsp_valid=2'b01, data=12 two cycles after accept.
- Simultaneous requests, RR=1, both held valid: req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grant order 0 then 1; responses 7 then 0xFF; rsp_valid 2'b01 then 2'b10; the next tie goes to 0.
- Response backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid -> data stays constant, busy=1, ready=2'b00 while req1 is valid; req1 is accepted only after the rsp0 handshake.
- Non-owner ready ignored: owner=1, rsp_ready=2'b01 -> rsp_valid[1] is held; state remains RESP.
- RR=0 starvation check: both continuously valid -> requester 0 is granted every time; req1 is never granted.
- Async reset asserted during EXEC: outputs go to reset values immediately without a clock; after release, no stale rsp_valid appears; a new req1 SLL a=1 b=4 returns 16.
